// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for the shared combinational ALU.
// Accepts one op at a time, holds operands on the ALU for ALU_WAIT+1 cycles, returns a tagged response.
module alu_req_arbiter #(
    parameter int DATA_W   = 19,
    parameter int OPC_W    = 5,
    parameter int ALU_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_illegal,
    output logic              resp_divz,
    output logic              busy
);

    localparam logic [3:0]       WAIT_INIT = 4'(ALU_WAIT);
    localparam logic [OPC_W-1:0] OPC_LAST  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        cnt;
    logic              last_grant;
    logic              grant_valid;
    logic              grant_id;
    logic [OPC_W-1:0]  sel_opcode;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Grant is only offered in IDLE; on contention the requester not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    always_comb begin
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid &&  grant_id;
        sel_opcode = grant_id ? req1_opcode : req0_opcode;
        sel_a      = grant_id ? req1_a      : req0_a;
        sel_b      = grant_id ? req1_b      : req0_b;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_valid)     state_next = EXEC;
            EXEC: if (cnt == 4'd0)     state_next = RESP;
            RESP: if (resp_ready)      state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            last_grant   <= 1'b1;
            alu_opcode   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            resp_id      <= 1'b0;
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
            resp_divz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_opcode   <= sel_opcode;
                        alu_a        <= sel_a;
                        alu_b        <= sel_b;
                        resp_id      <= grant_id;
                        resp_illegal <= (sel_opcode > OPC_LAST);
                        resp_divz    <= (sel_opcode == OPC_DIV) && (sel_b == '0);
                        last_grant   <= grant_id;
                        cnt          <= WAIT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_result <= alu_result;
                        resp_zero   <= alu_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomised bench for alu_req_arbiter with a stub ALU and a transaction-level timeline model.
module tb_alu_req_arbiter;

    localparam int DW = 19;
    localparam int OW = 5;
    localparam int W  = 1;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [OW-1:0] req0_opcode, req1_opcode;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] alu_opcode;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_zero;
    logic          resp_valid, resp_ready, resp_id;
    logic [DW-1:0] resp_result;
    logic          resp_zero, resp_illegal, resp_divz, busy;

    alu_req_arbiter #(.DATA_W(DW), .OPC_W(OW), .ALU_WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_illegal(resp_illegal), .resp_divz(resp_divz), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] o, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (o)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a * b;
            5'd3: r = (b == '0) ? '0 : a / b;
            5'd4: r = a & b;
            5'd5: r = a | b;
            5'd6: r = a ^ b;
            5'd7: r = a << b[3:0];
            5'd8: r = a >> b[3:0];
            5'd9: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_opcode, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: an accepted op owns the ALU until its response is consumed.
    bit            m_pend;
    int            m_resp_at;
    bit            m_last;
    bit            m_id;
    logic [OW-1:0] m_opc;
    logic [DW-1:0] m_a, m_b;
    bit            acc_seen;
    bit            acc_id;
    int            grants[$];

    task automatic model_reset();
        m_pend = 0;
        m_last = 1;
        m_id   = 0;
        m_opc  = '0;
        m_a    = '0;
        m_b    = '0;
    endtask

    task automatic model_check();
        bit            g;
        bit            any;
        logic [DW-1:0] r;
        acc_seen = 0;
        if (!rst_n) begin
            check("rst_busy", 32'(busy), 0);
            check("rst_resp_valid", 32'(resp_valid), 0);
            check("rst_alu_opcode", 32'(alu_opcode), 0);
            return;
        end
        if (!m_pend) begin
            any = req0_valid || req1_valid;
            g   = (req0_valid && req1_valid) ? !m_last : !req0_valid;
            check("ready0", 32'(req0_ready), 32'(any && !g));
            check("ready1", 32'(req1_ready), 32'(any && g));
            check("idle_busy", 32'(busy), 0);
            check("idle_resp_valid", 32'(resp_valid), 0);
            check("idle_alu_opcode", 32'(alu_opcode), 32'(m_opc));
            check("idle_alu_a", 32'(alu_a), 32'(m_a));
            if (any) begin
                m_pend    = 1;
                m_resp_at = cyc + W + 2;
                m_last    = g;
                m_id      = g;
                m_opc     = g ? req1_opcode : req0_opcode;
                m_a       = g ? req1_a : req0_a;
                m_b       = g ? req1_b : req0_b;
                acc_seen  = 1;
                acc_id    = g;
                grants.push_back(int'(g));
            end
        end else begin
            check("busy_ready0", 32'(req0_ready), 0);
            check("busy_ready1", 32'(req1_ready), 0);
            check("busy", 32'(busy), 1);
            check("alu_opcode", 32'(alu_opcode), 32'(m_opc));
            check("alu_a", 32'(alu_a), 32'(m_a));
            check("alu_b", 32'(alu_b), 32'(m_b));
            check("resp_valid", 32'(resp_valid), 32'(cyc >= m_resp_at));
            if (cyc >= m_resp_at) begin
                r = alu_fn(m_opc, m_a, m_b);
                check("resp_id", 32'(resp_id), 32'(m_id));
                check("resp_result", 32'(resp_result), 32'(r));
                check("resp_zero", 32'(resp_zero), 32'(r == '0));
                check("resp_illegal", 32'(resp_illegal), 32'(m_opc > 5'd9));
                check("resp_divz", 32'(resp_divz), 32'(m_opc == 5'd3 && m_b == '0));
                if (resp_ready) m_pend = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit port, input logic [OW-1:0] o, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (port) begin
            req1_valid = 1; req1_opcode = o; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1; req0_opcode = o; req0_a = a; req0_b = b;
        end
    endtask

    task automatic issue(input bit port, input logic [OW-1:0] o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        bit done = 0;
        set_req(port, o, a, b);
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (acc_seen && acc_id == port) done = 1;
        end
        check("issue_accepted", 32'(done), 1);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_pend; i++) step();
        check("drain_done", 32'(m_pend), 0);
    endtask

    initial begin
        rst_n = 0; resp_ready = 1;
        req0_valid = 0; req0_opcode = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_opcode = '0; req1_a = '0; req1_b = '0;
        model_reset();
        #1;
        check("reset_req0_ready", 32'(req0_ready), 0);
        check("reset_resp_result", 32'(resp_result), 0);
        check("reset_resp_id", 32'(resp_id), 0);
        step(); step();
        rst_n = 1;
        step();

        // ADD 5+7 from requester 0, latency checked by the model timeline
        issue(0, 5'd0, 19'd5, 19'd7);
        drain();

        // Both valid: grants must alternate
        grants.delete();
        set_req(0, 5'd1, 19'd100, 19'd1);
        set_req(1, 5'd4, 19'h7fff0, 19'h0ff0f);
        for (int i = 0; i < 4 * (W + 3); i++) step();
        req0_valid = 0; req1_valid = 0;
        drain();
        check("alt_count", 32'(grants.size()), 4);
        for (int i = 1; i < grants.size(); i++)
            check("alt_order", 32'(grants[i]), 32'(1 - grants[i-1]));

        // Divide by zero, illegal opcode
        issue(1, 5'd3, 19'd9, 19'd0);
        drain();
        issue(0, 5'd31, 19'd1234, 19'd5);
        drain();

        // Consumer back-pressure with both requesters waiting
        resp_ready = 0;
        issue(0, 5'd6, 19'h12345, 19'h0f0f0);
        set_req(0, 5'd0, 19'd1, 19'd1);
        set_req(1, 5'd0, 19'd2, 19'd2);
        for (int i = 0; i < W + 2 + 10; i++) step();
        req0_valid = 0; req1_valid = 0;
        resp_ready = 1;
        step();
        step();
        check("release_idle", 32'(busy), 0);

        // Async reset in the middle of EXEC
        issue(1, 5'd2, 19'd300, 19'd3);
        rst_n = 0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_resp_valid", 32'(resp_valid), 0);
        check("midrst_alu_a", 32'(alu_a), 0);
        check("midrst_alu_b", 32'(alu_b), 0);
        check("midrst_resp_id", 32'(resp_id), 0);
        check("midrst_resp_result", 32'(resp_result), 0);
        model_reset();
        step(); step();
        rst_n = 1;
        for (int i = 0; i < 5; i++) step();
        grants.delete();
        set_req(0, 5'd5, 19'd3, 19'd4);
        set_req(1, 5'd5, 19'd5, 19'd6);
        step();
        req0_valid = 0; req1_valid = 0;
        check("post_reset_grant", 32'(grants.size() > 0 ? grants[0] : 2), 0);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            req0_valid  = ($urandom_range(0, 1) == 1);
            req1_valid  = ($urandom_range(0, 1) == 1);
            req0_opcode = ($urandom_range(0, 7) == 0) ? OW'($urandom) : OW'($urandom_range(0, 9));
            req1_opcode = ($urandom_range(0, 7) == 0) ? OW'($urandom) : OW'($urandom_range(0, 9));
            req0_a      = DW'($urandom);
            req1_a      = DW'($urandom);
            req0_b      = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            req1_b      = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            resp_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        req0_valid = 0; req1_valid = 0; resp_ready = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
